page_table_walker: RTL and testbench
====================================

PAGE_TABLE_WALKER -- requirements
Module: page_table_walker

Interface
REQ-001 SHALL have parameter MEM_LAT_MAX, default 255, meaning memory-wait cycles before a walk is abandoned with a fault.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on its rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: csr_satp in 32 (mode bit 31, root PPN 19:0); priv in 2; sstatus_sum in 1; flush in 1, abandons the current walk.
REQ-005 SHALL have instruction-side ports: i_req in 1; i_va in 32; i_ack out 1; i_pa out 32; i_fault out 1.
REQ-006 SHALL have data-side ports: d_req in 1; d_va in 32; d_is_store in 1 (0 = load); d_ack out 1; d_pa out 32; d_fault out 1.
REQ-007 SHALL have memory ports: mem_req out 1; mem_addr out 32; mem_valid in 1; mem_rdata in 32 (PTE).
REQ-008 SHALL have faulting_va out 32, the captured VA of the last completed request.

Function
REQ-009 SHALL implement states IDLE, L1, L0, RESP, DRAIN.
REQ-010 In IDLE, the walker SHALL grant a requester: sole i_req or d_req wins; when both are asserted, the side not granted last wins; the last-grant register resets to instruction, so data wins the first tie.
REQ-011 On grant, the walker SHALL capture va, side, is_store, satp, priv and sum; later input changes SHALL NOT affect the walk.
REQ-012 If captured satp[31]=0 (bare), the walker SHALL go IDLE->RESP with pa=va, fault=0 (ack 1 cycle after grant).
REQ-013 Otherwise it SHALL go to L1: mem_req=1, mem_addr={satp[19:0],12'b0}+{va[31:22],2'b00}, both held stable until mem_valid is sampled high.
REQ-014 PTE flag bits: V=0 R=1 W=2 X=3 U=4 A=6 D=7.
REQ-015 A fault SHALL be raised on any of:
  - V=0;
  - W=1 with R=0;
  - U=0 in user mode;
  - U=1 in supervisor mode with sum=0;
  - U=1 on a supervisor instruction access;
  - A=0;
  - instruction access with X=0;
  - load with R=0;
  - store with W=0 or D=0.
REQ-016 An L1 PTE with R=0 and X=0 SHALL be a pointer: go to L0, mem_addr={pte[29:10],12'b0}+{va[21:12],2'b00}; U/A/D/permission checks SHALL NOT apply to a pointer.
REQ-017 An L1 leaf with pte[19:10]!=0 SHALL fault (misaligned superpage); otherwise pa={pte[29:20],va[21:0]}.
REQ-018 An L0 PTE SHALL be a leaf: R=0 and X=0 faults; otherwise pa={pte[29:10],va[11:0]}.
REQ-019 RESP SHALL last exactly 1 cycle, then go to IDLE. During RESP:
  - only the granted side's ack is high;
  - its pa and fault are valid (pa=0 when fault=1);
  - faulting_va equals the captured va.
  Requesters drop req in the cycle after ack.
REQ-020 A memory-wait counter SHALL clear on each mem_req issue; on reaching MEM_LAT_MAX without mem_valid, the walker SHALL go to RESP with fault=1 and mem_req=0.
REQ-021 flush high in L1 or L0 SHALL go to DRAIN with no ack; DRAIN keeps mem_req=0, waits for mem_valid (or the counter limit), then goes to IDLE.
REQ-022 flush high in IDLE or RESP SHALL be ignored; an ack in RESP still fires.
REQ-023 No grant SHALL occur outside IDLE; ack SHALL never fire for a non-granted side.

Reset
REQ-024 While rst_n=0, the walker SHALL be in state IDLE, last-grant=instruction, counter=0, and all outputs 0 (i_ack, d_ack, i_pa, d_pa, i_fault, d_fault, mem_req, mem_addr, faulting_va).
REQ-025 Reset mid-walk SHALL abandon the walk without ack; a mem_valid arriving after rst_n release while in IDLE SHALL be ignored.

Verification
REQ-026 Bare mode: satp=0, i_req, i_va=0x1234_5678 -> i_ack 1 cycle after grant, i_pa=0x1234_5678, i_fault=0, mem_req never high.
REQ-027 Two-level load: satp=0x8000_0100, priv=S, d_va=0x0040_1234, L1 PTE 0x0004_8001 at 0x0010_0004, L0 PTE 0x2000_00CF at 0x0012_0004 -> d_pa=0x8000_0234, d_fault=0.
REQ-028 Superpage, same satp/va, L1 PTE 0x2000_00CF -> pa=0x8000_1234; L1 PTE 0x2000_04CF -> fault=1, pa=0, faulting_va=0x0040_1234.
REQ-029 Store to L0 PTE 0x2000_004F (D=0) -> d_fault=1; user-mode load of U=0 PTE -> fault; S-mode load of U=1 PTE: sum=1 passes, sum=0 faults.
REQ-030 i_req and d_req rise together -> data served first, then instruction; only one ack per RESP; grants alternate while both are held.
REQ-031 flush one cycle after L1 mem_req -> no ack; mem_valid 3 cycles later is consumed in DRAIN; a following i_req walks correctly; mem_valid withheld -> fault after MEM_LAT_MAX cycles.

Source files
------------

// File: rtl/page_table_walker.sv
// Two-level (Sv32-style) page table walker shared by an instruction and a data
// requester. One walk at a time; the result is presented for a single RESP cycle.
module page_table_walker #(
  parameter int unsigned MEM_LAT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] csr_satp,
  input  logic [1:0]  priv,
  input  logic        sstatus_sum,
  input  logic        flush,
  input  logic        i_req,
  input  logic [31:0] i_va,
  output logic        i_ack,
  output logic [31:0] i_pa,
  output logic        i_fault,
  input  logic        d_req,
  input  logic [31:0] d_va,
  input  logic        d_is_store,
  output logic        d_ack,
  output logic [31:0] d_pa,
  output logic        d_fault,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] faulting_va
);

  localparam int unsigned CW = $clog2(MEM_LAT_MAX + 1);
  localparam logic [CW-1:0] CNT_LIM = CW'(MEM_LAT_MAX - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] L1    = 3'd1;
  localparam logic [2:0] L0    = 3'd2;
  localparam logic [2:0] RESP  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          last_q, last_d;    // 1 = data side granted last
  logic          side_q, side_d;    // 1 = data side owns the walk
  logic          store_q, store_d;
  logic [31:0]   va_q, va_d;
  logic [19:0]   root_q, root_d;
  logic [1:0]    priv_q, priv_d;
  logic          sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   pa_q, pa_d;
  logic          fault_q, fault_d;
  logic [31:0]   fva_q, fva_d;

  logic          gnt_data;
  logic [31:0]   gnt_va;
  logic          go_resp;
  logic          resp_fault;
  logic [31:0]   resp_pa;

  logic unused_bits;
  assign unused_bits = ^{csr_satp[30:20], mem_rdata[31:30], mem_rdata[9:8], mem_rdata[5]};

  // Data wins a tie unless it was the side granted last.
  assign gnt_data = d_req & (~i_req | ~last_q);
  assign gnt_va   = gnt_data ? d_va : i_va;

  // Permission/flag checks applied to any leaf PTE.
  function automatic logic leaf_fault(input logic [31:0] pte, input logic inst,
                                      input logic store, input logic [1:0] prv,
                                      input logic sum);
    logic user, sup, load;
    user = (prv == 2'b00);
    sup  = (prv == 2'b01);
    load = !inst && !store;
    leaf_fault = !pte[0] || (pte[2] && !pte[1]) || (user && !pte[4]) ||
                 (sup && pte[4] && !sum) || (sup && pte[4] && inst) || !pte[6] ||
                 (inst && !pte[3]) || (load && !pte[1]) || (store && (!pte[2] || !pte[7]));
  endfunction

  // Next-state, walk sequencing and result computation.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    side_d     = side_q;
    store_d    = store_q;
    va_d       = va_q;
    root_d     = root_q;
    priv_d     = priv_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    pa_d       = pa_q;
    fault_d    = fault_q;
    fva_d      = fva_q;
    go_resp    = 1'b0;
    resp_fault = 1'b0;
    resp_pa    = '0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          side_d  = gnt_data;
          last_d  = gnt_data;
          va_d    = gnt_va;
          store_d = gnt_data & d_is_store;
          root_d  = csr_satp[19:0];
          priv_d  = priv;
          sum_d   = sstatus_sum;
          cnt_d   = '0;
          if (!csr_satp[31]) begin
            state_d = RESP;
            pa_d    = gnt_va;
            fault_d = 1'b0;
            fva_d   = gnt_va;
          end else begin
            state_d = L1;
            addr_d  = {csr_satp[19:0], 12'b0} + {20'b0, gnt_va[31:22], 2'b00};
          end
        end
      end
      L1: begin
        if (flush) begin
          // A response landing in the same cycle is already consumed.
          state_d = mem_valid ? IDLE : DRAIN;
        end else if (mem_valid) begin
          if (!mem_rdata[0] || (mem_rdata[2] && !mem_rdata[1])) begin
            go_resp    = 1'b1;
            resp_fault = 1'b1;
          end else if (!mem_rdata[1] && !mem_rdata[3]) begin
            state_d = L0;
            cnt_d   = '0;
            addr_d  = {mem_rdata[29:10], 12'b0} + {20'b0, va_q[21:12], 2'b00};
          end else begin
            go_resp    = 1'b1;
            resp_fault = leaf_fault(mem_rdata, !side_q, store_q, priv_q, sum_q) ||
                         (mem_rdata[19:10] != 10'd0);
            resp_pa    = {mem_rdata[29:20], va_q[21:0]};
          end
        end else if (cnt_q == CNT_LIM) begin
          go_resp    = 1'b1;
          resp_fault = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      L0: begin
        if (flush) begin
          state_d = mem_valid ? IDLE : DRAIN;
        end else if (mem_valid) begin
          go_resp    = 1'b1;
          resp_fault = (!mem_rdata[1] && !mem_rdata[3]) ||
                       leaf_fault(mem_rdata, !side_q, store_q, priv_q, sum_q);
          resp_pa    = {mem_rdata[29:10], va_q[11:0]};
        end else if (cnt_q == CNT_LIM) begin
          go_resp    = 1'b1;
          resp_fault = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: state_d = IDLE;
      DRAIN: begin
        if (mem_valid || cnt_q == CNT_LIM) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (go_resp) begin
      state_d = RESP;
      fault_d = resp_fault;
      pa_d    = resp_fault ? 32'd0 : resp_pa;
      fva_d   = va_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      side_q  <= 1'b0;
      store_q <= 1'b0;
      va_q    <= '0;
      root_q  <= '0;
      priv_q  <= '0;
      sum_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      pa_q    <= '0;
      fault_q <= 1'b0;
      fva_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      side_q  <= side_d;
      store_q <= store_d;
      va_q    <= va_d;
      root_q  <= root_d;
      priv_q  <= priv_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      pa_q    <= pa_d;
      fault_q <= fault_d;
      fva_q   <= fva_d;
    end
  end

  logic unused_root;
  assign unused_root = ^root_q;

  assign i_ack       = (state_q == RESP) && !side_q;
  assign d_ack       = (state_q == RESP) && side_q;
  assign i_pa        = i_ack ? pa_q : 32'd0;
  assign d_pa        = d_ack ? pa_q : 32'd0;
  assign i_fault     = i_ack & fault_q;
  assign d_fault     = d_ack & fault_q;
  assign mem_req     = (state_q == L1) || (state_q == L0);
  assign mem_addr    = mem_req ? addr_q : 32'd0;
  assign faulting_va = fva_q;

endmodule

// File: tb/tb_page_table_walker.sv
// Directed bench for page_table_walker: bare mode, two-level and superpage walks,
// permission faults, arbitration, flush/drain, timeout and reset behaviour.
module tb_page_table_walker;

  localparam int unsigned LAT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] csr_satp;
  logic [1:0]  priv;
  logic        sstatus_sum, flush;
  logic        i_req, i_ack, i_fault;
  logic [31:0] i_va, i_pa;
  logic        d_req, d_is_store, d_ack, d_fault;
  logic [31:0] d_va, d_pa;
  logic        mem_req, mem_valid;
  logic [31:0] mem_addr, mem_rdata, faulting_va;

  int total = 0;
  int bad   = 0;

  page_table_walker #(.MEM_LAT_MAX(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .csr_satp(csr_satp), .priv(priv), .sstatus_sum(sstatus_sum),
    .flush(flush), .i_req(i_req), .i_va(i_va), .i_ack(i_ack), .i_pa(i_pa), .i_fault(i_fault),
    .d_req(d_req), .d_va(d_va), .d_is_store(d_is_store), .d_ack(d_ack), .d_pa(d_pa),
    .d_fault(d_fault), .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata), .faulting_va(faulting_va)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Waits for mem_req, checks address and wait time, then returns one PTE after lat cycles.
  task automatic mem_serve(input string tag, input logic [31:0] exp_addr, input logic [31:0] pte,
                           input int lat, input int exp_wait);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_wait"}, n, exp_wait);
    chk({tag, "_addr"}, mem_addr, exp_addr);
    repeat (lat) @(negedge clk);
    chk({tag, "_hold"}, {mem_req, mem_addr[30:0]}, {1'b1, exp_addr[30:0]});
    mem_valid = 1'b1;
    mem_rdata = pte;
    @(negedge clk);
    mem_valid = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic wait_ack(input string tag, input bit dside, input logic [31:0] exp_pa,
                          input logic exp_flt, input logic [31:0] exp_va, output int cyc,
                          output logic mem_seen);
    logic other_seen;
    other_seen = 1'b0;
    mem_seen   = 1'b0;
    cyc        = 0;
    while (((dside ? d_ack : i_ack) !== 1'b1) && cyc < 40) begin
      if ((dside ? i_ack : d_ack) === 1'b1) other_seen = 1'b1;
      if (mem_req === 1'b1) mem_seen = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (mem_req === 1'b1) mem_seen = 1'b1;
    chk({tag, "_ack"}, {31'b0, (dside ? d_ack : i_ack)}, 32'd1);
    chk({tag, "_other"}, {31'b0, other_seen | (dside ? i_ack : d_ack)}, 32'd0);
    chk({tag, "_pa"}, dside ? d_pa : i_pa, exp_pa);
    chk({tag, "_fault"}, {31'b0, (dside ? d_fault : i_fault)}, {31'b0, exp_flt});
    chk({tag, "_fva"}, faulting_va, exp_va);
    if (dside) d_req = 1'b0;
    else i_req = 1'b0;
    @(negedge clk);
    chk({tag, "_onecyc"}, {30'b0, i_ack, d_ack}, 32'd0);
  endtask

  // Data-side walk through the L1 pointer 0x0004_8001 to the given L0 PTE.
  task automatic d_walk2(input string tag, input logic [31:0] l0pte, input logic [31:0] exp_pa,
                         input logic exp_flt);
    int c;
    logic m;
    d_va  = 32'h0040_1234;
    d_req = 1'b1;
    mem_serve({tag, "_l1"}, 32'h0010_0004, 32'h0004_8001, 0, 1);
    mem_serve({tag, "_l0"}, 32'h0012_0004, l0pte, 0, 0);
    wait_ack(tag, 1'b1, exp_pa, exp_flt, 32'h0040_1234, c, m);
  endtask

  initial begin
    int   cyc, n, mcnt;
    logic mseen, e_d, e_i;
    rst_n = 1'b0; csr_satp = '0; priv = 2'b01; sstatus_sum = 1'b0; flush = 1'b0;
    i_req = 1'b0; i_va = '0; d_req = 1'b0; d_va = '0; d_is_store = 1'b0;
    mem_valid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_flags", {27'b0, i_ack, d_ack, i_fault, d_fault, mem_req}, 32'd0);
    chk("rst_ipa", i_pa, 32'd0);
    chk("rst_dpa", d_pa, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_fva", faulting_va, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Tie from reset: data first, then alternate while both are held.
    i_va = 32'h1111_0000; d_va = 32'h2222_0000;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      e_d = (k % 4 == 1);
      e_i = (k % 4 == 3);
      chk($sformatf("alt_ack%0d", k), {30'b0, i_ack, d_ack}, {30'b0, e_i, e_d});
      if (e_d) chk("alt_dpa", d_pa, 32'h2222_0000);
      if (e_i) chk("alt_ipa", i_pa, 32'h1111_0000);
      if (k == 7) begin
        i_req = 1'b0; d_req = 1'b0;
      end
    end

    // Bare mode, with flush held through IDLE and RESP (ignored there).
    i_va = 32'h1234_5678; i_req = 1'b1; flush = 1'b1;
    wait_ack("bare", 1'b0, 32'h1234_5678, 1'b0, 32'h1234_5678, cyc, mseen);
    chk("bare_lat", cyc, 32'd1);
    chk("bare_nomem", {31'b0, mseen}, 32'd0);
    flush = 1'b0;

    // Misaligned superpage.
    csr_satp = 32'h8000_0100; priv = 2'b01;
    d_va = 32'h0040_1234; d_req = 1'b1;
    mem_serve("mis_l1", 32'h0010_0004, 32'h2000_04CF, 1, 1);
    wait_ack("mis", 1'b1, 32'd0, 1'b1, 32'h0040_1234, cyc, mseen);

    // Two-level load; inputs changed after grant must not matter.
    d_req = 1'b1;
    @(negedge clk);
    d_va = 32'hFFFF_FFFF; csr_satp = 32'h0; priv = 2'b00; d_is_store = 1'b1;
    mem_serve("w2_l1", 32'h0010_0004, 32'h0004_8001, 2, 0);
    mem_serve("w2_l0", 32'h0012_0004, 32'h2000_00CF, 0, 0);
    wait_ack("w2", 1'b1, 32'h8000_0234, 1'b0, 32'h0040_1234, cyc, mseen);
    csr_satp = 32'h8000_0100; priv = 2'b01; d_is_store = 1'b0;

    // Superpage leaf.
    d_va = 32'h0040_1234; d_req = 1'b1;
    mem_serve("sp_l1", 32'h0010_0004, 32'h2000_00CF, 1, 1);
    wait_ack("sp", 1'b1, 32'h8000_1234, 1'b0, 32'h0040_1234, cyc, mseen);

    // Stores, user mode and SUM.
    d_is_store = 1'b1;
    d_walk2("st_ok", 32'h2000_00CF, 32'h8000_0234, 1'b0);
    d_walk2("st_d0", 32'h2000_004F, 32'd0, 1'b1);
    d_is_store = 1'b0;
    priv = 2'b00;
    d_walk2("usr_u0", 32'h2000_00CF, 32'd0, 1'b1);
    priv = 2'b01; sstatus_sum = 1'b1;
    d_walk2("sum1", 32'h2000_00DF, 32'h8000_0234, 1'b0);
    sstatus_sum = 1'b0;
    d_walk2("sum0", 32'h2000_00DF, 32'd0, 1'b1);

    // Supervisor fetch from a U page faults even with SUM set.
    sstatus_sum = 1'b1;
    i_va = 32'h0040_1234; i_req = 1'b1;
    mem_serve("if_u_l1", 32'h0010_0004, 32'h0004_8001, 0, 1);
    mem_serve("if_u_l0", 32'h0012_0004, 32'h2000_00DF, 0, 0);
    wait_ack("if_u", 1'b0, 32'd0, 1'b1, 32'h0040_1234, cyc, mseen);
    sstatus_sum = 1'b0;

    // Flush one cycle into L1; late mem_valid is swallowed by DRAIN.
    d_va = 32'h0080_0000; d_req = 1'b1;
    @(negedge clk);
    chk("fl_l1req", {31'b0, mem_req}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; d_req = 1'b0;
    chk("fl_drain", {29'b0, mem_req, i_ack, d_ack}, 32'd0);
    @(negedge clk);
    chk("fl_drain2", {29'b0, mem_req, i_ack, d_ack}, 32'd0);
    @(negedge clk);
    mem_valid = 1'b1; mem_rdata = 32'h2000_00CF;
    @(negedge clk);
    mem_valid = 1'b0; mem_rdata = '0;
    chk("fl_idle", {29'b0, mem_req, i_ack, d_ack}, 32'd0);
    i_va = 32'h0040_1234; i_req = 1'b1;
    mem_serve("fl_i_l1", 32'h0010_0004, 32'h0004_8001, 0, 1);
    mem_serve("fl_i_l0", 32'h0012_0004, 32'h2000_00CF, 0, 0);
    wait_ack("fl_i", 1'b0, 32'h8000_0234, 1'b0, 32'h0040_1234, cyc, mseen);

    // Memory never answers: fault after LAT cycles of mem_req.
    d_va = 32'h00C0_0000; d_req = 1'b1;
    @(negedge clk);
    n = 0; mcnt = 0;
    while (d_ack !== 1'b1 && n < 40) begin
      if (mem_req === 1'b1) mcnt++;
      @(negedge clk);
      n++;
    end
    chk("to_cycles", mcnt, LAT);
    chk("to_ack", {30'b0, d_ack, d_fault}, 32'd3);
    chk("to_pa", d_pa, 32'd0);
    chk("to_memreq", {31'b0, mem_req}, 32'd0);
    chk("to_fva", faulting_va, 32'h00C0_0000);
    d_req = 1'b0;
    @(negedge clk);

    // Reset mid-walk, then a stray mem_valid in IDLE.
    d_va = 32'h0040_1234; d_req = 1'b1;
    @(negedge clk);
    chk("rw_l1", {31'b0, mem_req}, 32'd1);
    rst_n = 1'b0; d_req = 1'b0;
    #1;
    chk("rw_rst", {29'b0, mem_req, i_ack, d_ack}, 32'd0);
    chk("rw_fva", faulting_va, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_valid = 1'b1; mem_rdata = 32'h2000_00CF;
    @(negedge clk);
    mem_valid = 1'b0; mem_rdata = '0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rw_quiet%0d", k), {29'b0, mem_req, i_ack, d_ack}, 32'd0);
      @(negedge clk);
    end

    // Last-grant is instruction again after reset: data wins the tie.
    csr_satp = 32'h0;
    i_va = 32'h0000_0AAA; d_va = 32'h0000_0BBB;
    i_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    chk("rt_first", {30'b0, i_ack, d_ack}, 32'd1);
    d_req = 1'b0;
    @(negedge clk);
    wait_ack("rt_i", 1'b0, 32'h0000_0AAA, 1'b0, 32'h0000_0AAA, cyc, mseen);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
